// File: rtl/sim_watchdog.sv
// Run-control watchdog: global/heartbeat timeouts, post-end drain, sticky pass/fail verdict.
// Optional SIM_WATCHDOG_FINISH_EN: print the verdict and call $finish on entry to DONE.
module sim_watchdog #(
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 100000,
  parameter int HB_TIMEOUT   = 1000,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             hb,
  input  logic             dut_done,
  input  logic             dut_fail,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       reason,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] HB_LAST    = CNT_W'(HB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t           r_state;
  logic             r_running;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;
  logic [1:0]       r_reason;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_hb_cnt;
  logic [CNT_W-1:0] r_drain_cnt;

  logic             w_exit;
  logic             w_exit_fail;
  logic [1:0]       w_exit_reason;

  // Exit arbitration in RUN: the first matching condition alone sets the reason.
  always_comb begin
    w_exit        = 1'b1;
    w_exit_fail   = 1'b1;
    w_exit_reason = 2'd0;
    if (dut_fail) begin
      w_exit_reason = 2'd1;
    end else if (r_cycle_count == MAX_LAST) begin
      w_exit_reason = 2'd2;
    end else if ((r_hb_cnt == HB_LAST) && !hb) begin
      w_exit_reason = 2'd3;
    end else if (dut_done) begin
      w_exit_fail   = 1'b0;
    end else begin
      w_exit        = 1'b0;
      w_exit_fail   = 1'b0;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_running     <= 1'b1;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_reason      <= 2'd0;
      r_cycle_count <= '0;
      r_hb_cnt      <= '0;
      r_drain_cnt   <= '0;
    end else begin
      if (r_cycle_count != '1) begin
        r_cycle_count <= r_cycle_count + ONE;
      end
      case (r_state)
        S_RUN: begin
          r_hb_cnt <= hb ? '0 : r_hb_cnt + ONE;
          if (w_exit) begin
            r_running   <= 1'b0;
            r_fail      <= w_exit_fail;
            r_reason    <= w_exit_reason;
            r_drain_cnt <= '0;
            if (DRAIN_CYCLES == 0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_pass  <= ~w_exit_fail;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // A late dut_fail only matters when the drain started from a passing end.
          if (dut_fail && !r_fail) begin
            r_fail   <= 1'b1;
            r_reason <= 2'd1;
          end
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= ~(r_fail | dut_fail);
          end else begin
            r_drain_cnt <= r_drain_cnt + ONE;
          end
        end
        default: begin
          r_state <= S_DONE;
        end
      endcase
    end
  end

  assign running     = r_running;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign reason      = r_reason;
  assign cycle_count = r_cycle_count;
  assign dbg_state   = r_state;

`ifdef SIM_WATCHDOG_FINISH_EN
  logic r_done_d;

  always_ff @(posedge ck) begin
    r_done_d <= rst ? 1'b0 : r_done;
  end

  always @(negedge ck) begin
    if (!rst && r_done && !r_done_d) begin
      $display("sim_watchdog: verdict=%s reason=%0d cycle_count=%0d",
               r_pass ? "PASS" : "FAILED", r_reason, r_cycle_count);
      $finish;
    end
  end
`else
  // Harness polls done/pass; nothing simulation-only is built here.
`endif

endmodule

// File: tb/tb_sim_watchdog.sv
// Directed bench for sim_watchdog: two instances (DRAIN_CYCLES=16 and 0) share stimulus;
// done/fail edges are checked by a monitor against queued expected verdicts.
module tb_sim_watchdog;

  localparam int W  = 32;
  localparam int DW = 36;  // {reason, fail, pass, cycle_count}
  localparam int FW = 35;  // {reason, running, cycle_count}

  logic          ck = 1'b0;
  logic          rst = 1'b1;
  logic          hb = 1'b0;
  logic          dut_done = 1'b0;
  logic          dut_fail = 1'b0;

  logic          running, done, pass, fail;
  logic [1:0]    reason, dbg_state;
  logic [W-1:0]  cycle_count;
  logic          running0, done0, pass0, fail0;
  logic [1:0]    reason0, dbg_state0;
  logic [W-1:0]  cycle_count0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp0_q[$];
  logic [FW-1:0] expf_q[$];

  int compared = 0;
  int mismatched = 0;

  sim_watchdog #(.CNT_W(W), .MAX_CYCLES(500), .HB_TIMEOUT(100), .DRAIN_CYCLES(16)) u_dut (
    .ck(ck), .rst(rst), .hb(hb), .dut_done(dut_done), .dut_fail(dut_fail),
    .running(running), .done(done), .pass(pass), .fail(fail), .reason(reason),
    .cycle_count(cycle_count), .dbg_state(dbg_state)
  );

  sim_watchdog #(.CNT_W(W), .MAX_CYCLES(500), .HB_TIMEOUT(100), .DRAIN_CYCLES(0)) u_dut0 (
    .ck(ck), .rst(rst), .hb(hb), .dut_done(dut_done), .dut_fail(dut_fail),
    .running(running0), .done(done0), .pass(pass0), .fail(fail0), .reason(reason0),
    .cycle_count(cycle_count0), .dbg_state(dbg_state0)
  );

  // Clock / reset
  always #5 ck = ~ck;

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: cycle c is the cycle during which cycle_count == c.
  task automatic run_test(input int n, input int hb_per, input int done_at,
                          input int fa, input int fb);
    for (int c = 0; c < n; c++) begin
      hb       = (hb_per > 0) && ((c % hb_per) == 0);
      dut_done = (c == done_at);
      dut_fail = (c == fa) || (c == fb);
      step();
    end
    hb       = 1'b0;
    dut_done = 1'b0;
    dut_fail = 1'b0;
  endtask

  // Scoreboard monitor
  logic done_p = 1'b0, done0_p = 1'b0, fail_p = 1'b0;

  always @(negedge ck) begin
    if (rst) begin
      done_p  = 1'b0;
      done0_p = 1'b0;
      fail_p  = 1'b0;
    end else begin
      if (done && !done_p) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL done16_unexpected: got done at cycle %0d expected none", cycle_count);
        end else begin
          check("done16_verdict", 64'({reason, fail, pass, cycle_count}), 64'(exp_q.pop_front()));
        end
      end
      if (done0 && !done0_p) begin
        if (exp0_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL done0_unexpected: got done at cycle %0d expected none", cycle_count0);
        end else begin
          check("done0_verdict", 64'({reason0, fail0, pass0, cycle_count0}), 64'(exp0_q.pop_front()));
        end
      end
      if (fail && !fail_p) begin
        if (expf_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL fail16_unexpected: got fail at cycle %0d expected none", cycle_count);
        end else begin
          check("fail16_edge", 64'({reason, running, cycle_count}), 64'(expf_q.pop_front()));
        end
      end
      done_p  = done;
      done0_p = done0;
      fail_p  = fail;
    end
  end

  task automatic check_drained(input string name);
    check({name, "_q16"}, 64'(exp_q.size()), 64'd0);
    check({name, "_q0"}, 64'(exp0_q.size()), 64'd0);
    check({name, "_qf"}, 64'(expf_q.size()), 64'd0);
    exp_q.delete();
    exp0_q.delete();
    expf_q.delete();
  endtask

  initial begin
    reset_dut();
    check("reset_flags", 64'({running, done, pass, fail, reason}), 64'(6'b100000));
    check("reset_count", 64'(cycle_count), 64'd0);
    check("reset_flags0", 64'({running0, done0, pass0, fail0, reason0}), 64'(6'b100000));

    // 1: clean end at cycle 50
    exp_q.push_back({2'd0, 1'b0, 1'b1, 32'd67});
    exp0_q.push_back({2'd0, 1'b0, 1'b1, 32'd51});
    run_test(80, 10, 50, -1, -1);
    check_drained("t1");

    // 2: heartbeat never arrives
    reset_dut();
    expf_q.push_back({2'd3, 1'b0, 32'd100});
    exp_q.push_back({2'd3, 1'b1, 1'b0, 32'd116});
    exp0_q.push_back({2'd3, 1'b1, 1'b0, 32'd100});
    run_test(130, 0, -1, -1, -1);
    check_drained("t2");

    // 3: global timeout
    reset_dut();
    expf_q.push_back({2'd2, 1'b0, 32'd500});
    exp_q.push_back({2'd2, 1'b1, 1'b0, 32'd516});
    exp0_q.push_back({2'd2, 1'b1, 1'b0, 32'd500});
    run_test(530, 5, -1, -1, -1);
    check_drained("t3");

    // 4: dut_fail outranks dut_done on the same cycle
    reset_dut();
    expf_q.push_back({2'd1, 1'b0, 32'd31});
    exp_q.push_back({2'd1, 1'b1, 1'b0, 32'd47});
    exp0_q.push_back({2'd1, 1'b1, 1'b0, 32'd31});
    run_test(60, 10, 30, 30, -1);
    check_drained("t4");

    // 5: late failure during drain; failure after DONE ignored
    reset_dut();
    expf_q.push_back({2'd1, 1'b0, 32'd46});
    exp_q.push_back({2'd1, 1'b1, 1'b0, 32'd57});
    exp0_q.push_back({2'd0, 1'b0, 1'b1, 32'd41});
    run_test(100, 10, 40, 45, 80);
    check("t5_hold16", 64'({done, pass, fail, reason}), 64'(5'b10101));
    check("t5_hold0", 64'({done0, pass0, fail0, reason0}), 64'(5'b11000));
    check_drained("t5");

    // 6: reset in the middle of drain
    reset_dut();
    exp0_q.push_back({2'd0, 1'b0, 1'b1, 32'd11});
    run_test(20, 10, 10, -1, -1);
    check("t6_in_drain", 64'({running, done, cycle_count}), 64'({1'b0, 1'b0, 32'd20}));
    rst = 1'b1;
    step();
    check("t6_reset_flags", 64'({running, done, pass, fail, reason}), 64'(6'b100000));
    check("t6_reset_count", 64'(cycle_count), 64'd0);
    check("t6_reset_flags0", 64'({running0, done0, pass0, fail0, reason0}), 64'(6'b100000));
    rst = 1'b0;
    step();
    step();
    step();
    check("t6_restart_count", 64'(cycle_count), 64'd3);
    check_drained("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
